vend_txn_ctrl: RTL
==================

# vend_txn_ctrl

Transaction controller for the vending machine, in the `clk_fsm` domain directly downstream of the input CDC stage. It consumes the synchronized one-cycle currency and item-select pulses and keeps the running credit. It holds a configurable per-item price/stock table, decides accept/reject for each selection, and sequences the dispense and change-return handshakes. It also returns credit on cancel or on inactivity timeout.

## Interface
- `NUM_ITEMS`, 16: number of valid item indices (0..NUM_ITEMS-1), ≤ 1024
- `CREDIT_W`, 12: width of credit, price and change values
- `MAX_CREDIT`, 1000: largest credit accepted; must be < 2^CREDIT_W
- `TIMEOUT_CYCLES`, 1000000: idle cycles in CREDIT before automatic refund; ≥ 2
- `clk_fsm` in 1: FSM clock
- `rst` in 1: synchronous, active-high reset
- `currency_valid_sync` in 1: one-cycle coin pulse
- `currency_value_sync` in 8: coin value, valid with pulse
- `item_select_valid_sync` in 1: one-cycle selection pulse
- `item_select_sync` in 10: selected item index, valid with pulse
- `cancel_req` in 1: one-cycle cancel pulse
- `cfg_we` in 1: table write strobe
- `cfg_addr` in 10: item index to write
- `cfg_price` in CREDIT_W: price written
- `cfg_stock` in 8: stock count written
- `dispense_ready` in 1: dispenser accepts item
- `change_ready` in 1: change unit accepts amount
- `credit` out CREDIT_W: current credit
- `coin_reject` out 1: one-cycle pulse, coin not accepted
- `sel_error` out 1: one-cycle pulse, selection refused
- `err_code` out 2: 01 invalid index, 10 sold out, 11 insufficient credit; valid with `sel_error`, else 00
- `dispense_valid` out 1: dispense request
- `dispense_item` out 10: item index, stable while `dispense_valid`
- `change_valid` out 1: change request
- `change_amount` out CREDIT_W: refund value, stable while `change_valid`
- `busy` out 1: high in CHECK, DISPENSE, CHANGE

## Operation
- States: IDLE, CREDIT, CHECK, DISPENSE, CHANGE.
- Reset: state IDLE. All outputs are 0. Credit and timeout counter are 0. All table prices and stocks are 0, so every item is sold out until configured.
- Coin in IDLE/CREDIT:
  - Reject if value==0 or credit+value > MAX_CREDIT. Compute the sum at CREDIT_W+1 bits. On reject, pulse `coin_reject` and leave credit unchanged.
  - Otherwise credit += value. Go to or stay in CREDIT, and clear the timeout counter.
- Coin in CHECK/DISPENSE/CHANGE: always rejected with `coin_reject`.
- Select in IDLE/CREDIT: latch the index and go to CHECK. Selects in other states are silently ignored.
- Coin and select in the same cycle: the coin is processed first. CHECK evaluates the updated credit.
- CHECK (exactly one cycle). Checks in priority order:
  - index ≥ NUM_ITEMS → err 01
  - stock==0 → err 10
  - credit < price → err 11
- On error: pulse `sel_error`/`err_code`. Go to CREDIT if credit>0, else IDLE.
- On success: credit -= price, stock -= 1, go to DISPENSE.
- DISPENSE: `dispense_valid`=1 with `dispense_item`. On `dispense_valid && dispense_ready`, go to CHANGE if remaining credit>0, else IDLE.
- CHANGE: `change_valid`=1, `change_amount`=credit. On handshake, credit=0 and go to IDLE.
- `cancel_req` in CREDIT: go to CHANGE. In any other state it is ignored.
- Timeout: the counter runs only in CREDIT. It clears on every accepted coin and on every select. When it reaches TIMEOUT_CYCLES-1, go to CHANGE.
- Config: `cfg_we` writes price and stock in any state. Writes with `cfg_addr` ≥ NUM_ITEMS are ignored.
- Config write to the item being decremented in the same cycle: CHECK uses the old values, and the config write wins for stock.
- Reset mid-handshake: `dispense_valid`/`change_valid` drop at the reset edge. The in-flight credit is discarded.

## Timing
- All outputs are registered.
- Coin pulse at edge N → `credit` or `coin_reject` updated at edge N+1.
- Select at edge N → CHECK in cycle N+1. Result at edge N+2: `dispense_valid` rises or `sel_error` pulses.
- A DISPENSE handshake at edge M:
  - with credit>0 → `dispense_valid` low and `change_valid` high at M+1
  - otherwise → `dispense_valid` low and state IDLE at M+1
- `dispense_valid`/`change_valid` are held with stable data until ready. Ready without valid has no effect.
- `coin_reject`/`sel_error` are exactly one cycle wide.

## Test plan
- **Basic purchase:** item 3 is configured with price 150, stock 2. Coins 100 then 100, then select 3. Required: credit 100, then 200. `dispense_valid` with item 3 appears 2 cycles after the select. After `dispense_ready`, `change_valid` with amount 50. After `change_ready`, credit is 0, state IDLE, stock[3]=1.
- **Errors:**
  - Select 20 → `sel_error`, err 01.
  - Select an unconfigured item 5 → err 10.
  - Item 3 at price 150 with credit 100 → err 11. Credit stays 100 and state is CREDIT.
- **Coin limits:**
  - Credit 950 plus coin 100 → `coin_reject`, credit stays 950.
  - Coin of value 0 → rejected.
  - Coin during DISPENSE → rejected, credit unchanged.
- **Simultaneous coin and select:** credit 100, then coin 50 and select 3 (price 150) in the same cycle. Required: dispense succeeds with no change phase.
- **Cancel and timeout:** with TIMEOUT_CYCLES=8:
  - Credit 70 and `cancel_req` → `change_valid` with amount 70.
  - Separately, credit 30 with no activity → `change_valid` with amount 30 after 8 cycles in CREDIT.
- **Backpressure and reset:** hold `dispense_ready` low for 10 cycles; valid and item must stay stable. Assert `rst` mid-DISPENSE: all outputs are 0 and state is IDLE at the next edge.

Source files
------------

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: running credit, per-item price/stock table,
// accept/reject of selections, dispense and change-return handshakes.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  S_IDLE     | no credit held, waiting for a coin or a selection
//  S_CREDIT   | credit held, inactivity timer running, cancel honoured
//  S_CHECK    | one cycle: validate latched selection against table/credit
//  S_DISPENSE | dispense request held until dispenser handshake
//  S_CHANGE   | change request (whole credit) held until change handshake
module vend_txn_ctrl #(
   parameter int NUM_ITEMS      = 16,
   parameter int CREDIT_W       = 12,
   parameter int MAX_CREDIT     = 1000,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                clk_fsm,
   input  logic                rst,
   input  logic                currency_valid_sync,
   input  logic [7:0]          currency_value_sync,
   input  logic                item_select_valid_sync,
   input  logic [9:0]          item_select_sync,
   input  logic                cancel_req,
   input  logic                cfg_we,
   input  logic [9:0]          cfg_addr,
   input  logic [CREDIT_W-1:0] cfg_price,
   input  logic [7:0]          cfg_stock,
   input  logic                dispense_ready,
   input  logic                change_ready,
   output logic [CREDIT_W-1:0] credit,
   output logic                coin_reject,
   output logic                sel_error,
   output logic [1:0]          err_code,
   output logic                dispense_valid,
   output logic [9:0]          dispense_item,
   output logic                change_valid,
   output logic [CREDIT_W-1:0] change_amount,
   output logic                busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CREDIT,
      S_CHECK,
      S_DISPENSE,
      S_CHANGE
   } state_t;

   localparam int                IDX_W    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
   localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CREDIT_W:0] MAX_SUM  = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [10:0]       N_ITEMS  = 11'(NUM_ITEMS);

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_INDEX    = 2'b01;
   localparam logic [1:0] ERR_SOLD_OUT = 2'b10;
   localparam logic [1:0] ERR_FUNDS    = 2'b11;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [TMO_W-1:0]    tmo_q, tmo_d;
   logic [9:0]          sel_idx_q, sel_idx_d;
   logic                coin_rej_q, coin_rej_d;
   logic                sel_err_q, sel_err_d;
   logic [1:0]          err_q, err_d;
   logic                disp_valid_q, disp_valid_d;
   logic [9:0]          disp_item_q, disp_item_d;
   logic                chg_valid_q, chg_valid_d;
   logic [CREDIT_W-1:0] chg_amt_q, chg_amt_d;
   logic                busy_q, busy_d;

   logic [CREDIT_W-1:0] price_q [NUM_ITEMS];
   logic [7:0]          stock_q [NUM_ITEMS];

   logic [IDX_W-1:0]    sel_slot, cfg_slot;
   logic [CREDIT_W-1:0] cur_price;
   logic [7:0]          cur_stock;
   logic                sel_in_range, cfg_hit, dec_stock;
   logic                open_state, coin_ok;
   logic [CREDIT_W:0]   coin_sum;
   logic [CREDIT_W-1:0] credit_coin;

   assign sel_slot     = sel_idx_q[IDX_W-1:0];
   assign cfg_slot     = cfg_addr[IDX_W-1:0];
   assign sel_in_range = {1'b0, sel_idx_q} < N_ITEMS;
   assign cfg_hit      = cfg_we && ({1'b0, cfg_addr} < N_ITEMS);
   assign cur_price    = price_q[sel_slot];
   assign cur_stock    = stock_q[sel_slot];

   // Sum is one bit wider than credit so an overflowing coin is still caught.
   assign open_state  = (state_q == S_IDLE) || (state_q == S_CREDIT);
   assign coin_sum    = {1'b0, credit_q} + (CREDIT_W+1)'(currency_value_sync);
   assign coin_ok     = currency_valid_sync && open_state &&
                        (currency_value_sync != 8'd0) && (coin_sum <= MAX_SUM);
   assign credit_coin = coin_ok ? coin_sum[CREDIT_W-1:0] : credit_q;

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      tmo_d      = tmo_q;
      sel_idx_d  = sel_idx_q;
      coin_rej_d = currency_valid_sync && !coin_ok;
      sel_err_d  = 1'b0;
      err_d      = ERR_NONE;
      dec_stock  = 1'b0;

      unique case (state_q)
         S_IDLE, S_CREDIT: begin
            credit_d = credit_coin;
            if (coin_ok) begin
               state_d = S_CREDIT;
               tmo_d   = '0;
            end
            if (item_select_valid_sync) begin
               sel_idx_d = item_select_sync;
               state_d   = S_CHECK;
               tmo_d     = '0;
            end else if (state_q == S_CREDIT) begin
               if (cancel_req) begin
                  state_d = S_CHANGE;
               end else if (!coin_ok) begin
                  if (tmo_q == TMO_LAST) state_d = S_CHANGE;
                  else                   tmo_d   = tmo_q + TMO_W'(1);
               end
            end
         end

         S_CHECK: begin
            if (!sel_in_range)            err_d = ERR_INDEX;
            else if (cur_stock == 8'd0)   err_d = ERR_SOLD_OUT;
            else if (credit_q < cur_price) err_d = ERR_FUNDS;

            if (err_d != ERR_NONE) begin
               sel_err_d = 1'b1;
               state_d   = (credit_q != '0) ? S_CREDIT : S_IDLE;
               tmo_d     = '0;
            end else begin
               credit_d  = credit_q - cur_price;
               dec_stock = 1'b1;
               state_d   = S_DISPENSE;
            end
         end

         S_DISPENSE: begin
            if (dispense_ready) state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
         end

         S_CHANGE: begin
            if (change_ready) begin
               credit_d = '0;
               state_d  = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Handshake outputs are registered from the next state, so data is
      // stable for the whole time the request is held.
      disp_valid_d = (state_d == S_DISPENSE);
      disp_item_d  = (state_d == S_DISPENSE) ? sel_idx_q : 10'd0;
      chg_valid_d  = (state_d == S_CHANGE);
      chg_amt_d    = (state_d == S_CHANGE) ? credit_d : '0;
      busy_d       = (state_d == S_CHECK) || (state_d == S_DISPENSE) ||
                     (state_d == S_CHANGE);
   end

   always_ff @(posedge clk_fsm) begin
      if (rst) begin
         state_q      <= S_IDLE;
         credit_q     <= '0;
         tmo_q        <= '0;
         sel_idx_q    <= '0;
         coin_rej_q   <= 1'b0;
         sel_err_q    <= 1'b0;
         err_q        <= ERR_NONE;
         disp_valid_q <= 1'b0;
         disp_item_q  <= '0;
         chg_valid_q  <= 1'b0;
         chg_amt_q    <= '0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         credit_q     <= credit_d;
         tmo_q        <= tmo_d;
         sel_idx_q    <= sel_idx_d;
         coin_rej_q   <= coin_rej_d;
         sel_err_q    <= sel_err_d;
         err_q        <= err_d;
         disp_valid_q <= disp_valid_d;
         disp_item_q  <= disp_item_d;
         chg_valid_q  <= chg_valid_d;
         chg_amt_q    <= chg_amt_d;
         busy_q       <= busy_d;
      end
   end

   // A config write issued in the same cycle as a decrement overrides it.
   always_ff @(posedge clk_fsm) begin
      if (rst) begin
         for (int i = 0; i < NUM_ITEMS; i++) begin
            price_q[i] <= '0;
            stock_q[i] <= '0;
         end
      end else begin
         if (dec_stock) stock_q[sel_slot] <= cur_stock - 8'd1;
         if (cfg_hit) begin
            price_q[cfg_slot] <= cfg_price;
            stock_q[cfg_slot] <= cfg_stock;
         end
      end
   end

   assign credit         = credit_q;
   assign coin_reject    = coin_rej_q;
   assign sel_error      = sel_err_q;
   assign err_code       = err_q;
   assign dispense_valid = disp_valid_q;
   assign dispense_item  = disp_item_q;
   assign change_valid   = chg_valid_q;
   assign change_amount  = chg_amt_q;
   assign busy           = busy_q;

endmodule
